// File: rtl/sine_phase_decoder.sv
// sine_phase_decoder: recovers the 8-bit phase of a signed sine sample.
// The sample magnitude is located in the generator's 64-entry quarter-wave
// table by a 6-step binary search. Sign and slope then select the quadrant.
module sine_phase_decoder #(
    parameter logic [7:0] PEAK_MAG = 8'h7E,
    parameter int         ITERS    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] sample,
    input  logic       slope_neg,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] phase,
    output logic       clip
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Quarter-wave table shared with sine_wave_generator: floor(127*sin(pi*i/128)).
    // It is a constant ROM, so it carries no reset.
    localparam logic [7:0] LUT [0:63] = '{
        8'h00, 8'h03, 8'h06, 8'h09, 8'h0C, 8'h0F, 8'h12, 8'h15,
        8'h18, 8'h1B, 8'h1E, 8'h21, 8'h24, 8'h27, 8'h2A, 8'h2D,
        8'h30, 8'h33, 8'h36, 8'h39, 8'h3B, 8'h3E, 8'h41, 8'h43,
        8'h46, 8'h49, 8'h4B, 8'h4E, 8'h50, 8'h52, 8'h55, 8'h57,
        8'h59, 8'h5B, 8'h5E, 8'h60, 8'h62, 8'h64, 8'h66, 8'h67,
        8'h69, 8'h6B, 8'h6C, 8'h6E, 8'h70, 8'h71, 8'h72, 8'h74,
        8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7A, 8'h7B, 8'h7B,
        8'h7C, 8'h7D, 8'h7D, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h7E
    };

    state_t      state;
    logic [8:0]  mag;        // |sample|; 9 bits so that 0x80 becomes 128
    logic        neg;
    logic        slope_q;
    logic [5:0]  lo;
    logic [5:0]  hi;
    logic [2:0]  cnt;

    logic [8:0]  capture_mag;
    logic [5:0]  mid;
    logic [5:0]  next_lo;
    logic [5:0]  next_hi;
    logic        last_step;

    // Folds sign and slope back onto the quarter-wave index.
    function automatic logic [7:0] map_phase(input logic [5:0] idx,
                                             input logic       n,
                                             input logic       s);
        logic [7:0] p;
        case ({n, s})
            2'b00:   p = {2'b00, idx};
            2'b01:   p = {2'b01, ~idx};
            2'b11:   p = {2'b10, idx};
            default: p = {2'b11, ~idx};
        endcase
        return p;
    endfunction

    // One binary-search step: narrow [lo,hi] towards the smallest entry >= mag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        capture_mag = 9'd0;
        mid         = 6'd0;
        next_lo     = lo;
        next_hi     = hi;
        last_step   = (cnt == 3'(ITERS - 1));

        capture_mag = sample[7] ? (9'd0 - {sample[7], sample}) : {1'b0, sample};
        mid         = 6'((7'(lo) + 7'(hi)) >> 1);
        if ({1'b0, LUT[mid]} >= mag) begin
            next_hi = mid;
        end else begin
            next_lo = mid + 6'd1;
        end
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            phase     <= 8'h00;
            clip      <= 1'b0;
            mag       <= 9'd0;
            neg       <= 1'b0;
            slope_q   <= 1'b0;
            lo        <= 6'd0;
            hi        <= 6'd63;
            cnt       <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag      <= capture_mag;
                        neg      <= sample[7];
                        slope_q  <= slope_neg;
                        lo       <= 6'd0;
                        hi       <= 6'd63;
                        cnt      <= 3'd0;
                        in_ready <= 1'b0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    lo  <= next_lo;
                    hi  <= next_hi;
                    cnt <= cnt + 3'd1;
                    if (last_step) begin
                        phase     <= map_phase(next_lo, neg, slope_q);
                        clip      <= (mag > {1'b0, PEAK_MAG});
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
